// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier slice.
//   booth_state_t : FSM state encoding (IDLE, CALC, DONE)
//   BOOTH_ADD/SUB : {Q[0], q_m1} pairs that select add / subtract of M
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration.
// Ports:
//   acc_in  [WIDTH:0]   accumulator A (guard bit included)
//   q_in    [WIDTH-1:0] multiplier register Q
//   qm1_in              extra bit q_m1
//   m_in    [WIDTH:0]   sign-extended multiplicand M
//   acc_out/q_out/qm1_out : next {A, Q, q_m1} after add/sub and arithmetic shift
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             qm1_in,
  input  logic [WIDTH:0]   m_in,
  output logic [WIDTH:0]   acc_out,
  output logic [WIDTH-1:0] q_out,
  output logic             qm1_out
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc_in;
    case ({q_in[0], qm1_in})
      BOOTH_ADD: sum = acc_in + m_in;
      BOOTH_SUB: sum = acc_in - m_in;
      default:   sum = acc_in;
    endcase
  end

  // Arithmetic right shift of {sum, Q, q_m1}, replicating the sign of sum.
  always_comb begin
    acc_out = {sum[WIDTH], sum[WIDTH:1]};
    q_out   = {sum[0], q_in[WIDTH-1:1]};
    qm1_out = q_in[0];
  end

endmodule

// File: rtl/booth_mult_n.sv
// Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH.
// Ports:
//   clk, rst_n (async, active low)
//   start   : request, sampled only in IDLE
//   a, b    : signed multiplicand / multiplier, captured at accept
//   busy    : high from the cycle after accept through the done cycle
//   done    : one-cycle pulse, product valid in that cycle
//   product : signed a*b, held until the next done
// Optional: define BOOTH_ZERO_SKIP_EN to finish in one cycle when a or b is zero.
module booth_mult_n
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  booth_state_t state, state_nxt;

  logic [WIDTH:0]   acc_r, m_r, acc_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             qm1_r, qm1_nxt;
  logic [CNT_W-1:0] cnt_r;

  logic accept;
  logic zero_op;
  logic last_iter;

  assign accept    = (state == IDLE) && start;
  assign last_iter = (state == CALC) && (cnt_r == CNT_W'(1));

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_r),
    .q_in    (q_r),
    .qm1_in  (qm1_r),
    .m_in    (m_r),
    .acc_out (acc_nxt),
    .q_out   (q_nxt),
    .qm1_out (qm1_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = zero_op ? DONE : CALC;
      CALC: if (cnt_r == CNT_W'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Operand / accumulator / counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      m_r   <= '0;
      q_r   <= '0;
      qm1_r <= 1'b0;
      cnt_r <= '0;
    end else if (accept) begin
      m_r   <= {a[WIDTH-1], a};
      acc_r <= '0;
      q_r   <= b;
      qm1_r <= 1'b0;
      cnt_r <= CNT_W'(WIDTH);
    end else if (state == CALC) begin
      acc_r <= acc_nxt;
      q_r   <= q_nxt;
      qm1_r <= qm1_nxt;
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Product loads only on the edge entering DONE; the final iteration's
  // result is taken straight from the step logic rather than the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else if (last_iter) begin
      product <= {acc_nxt[WIDTH-1:0], q_nxt};
    end else if (accept && zero_op) begin
      product <= '0;
    end
  end

endmodule

// File: tb/tb_booth_mult_n.sv
module tb_booth_mult_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        st4, st8, st16;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy4, busy8, busy16;
  logic        done4, done8, done16;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;

  int n_cmp = 0;
  int n_err = 0;

  booth_mult_n #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(p4)
  );
  booth_mult_n #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(p8)
  );
  booth_mult_n #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(p16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      4:       return busy4;
      8:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      4:       return done4;
      8:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int w);
    case (w)
      4:       return {24'd0, p4};
      8:       return {16'd0, p8};
      default: return p16;
    endcase
  endfunction

  task automatic set_in(input int w, input logic s, input logic [15:0] av, input logic [15:0] bv);
    case (w)
      4:       begin st4 = s;  a4 = av[3:0];  b4 = bv[3:0];  end
      8:       begin st8 = s;  a8 = av[7:0];  b8 = bv[7:0];  end
      default: begin st16 = s; a16 = av;      b16 = bv;      end
    endcase
  endtask

  // Reference: interpret low w bits as signed, multiply, keep 2w bits.
  function automatic longint sext(input logic [15:0] v, input int w);
    longint r;
    r = longint'(v) & ((longint'(1) << w) - 1);
    if (r >= (longint'(1) << (w - 1))) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic logic [31:0] ref_prod(input logic [15:0] av, input logic [15:0] bv, input int w);
    longint p;
    p = sext(av, w) * sext(bv, w);
    p = p & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [15:0] av, input logic [15:0] bv, input int w);
`ifdef BOOTH_ZERO_SKIP_EN
    if (sext(av, w) == 0 || sext(bv, w) == 0) return 1;
`endif
    return w + 1;
  endfunction

  // Wait (bounded) for done after an accept edge; counts cycles from accept
  // and checks product stays put until the done cycle.
  task automatic wait_done(input int w, input string tag, input logic [31:0] prev,
                           output int lat, output int nbusy);
    bit seen;
    seen  = 0;
    lat   = 0;
    nbusy = 0;
    for (int c = 1; c <= 64; c++) begin
      if (get_busy(w)) nbusy++;
      if (get_done(w)) begin
        lat  = c;
        seen = 1;
        break;
      end
      check({tag, "_hold"}, get_prod(w), prev);
      @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input int w, input string tag, input logic [15:0] av, input logic [15:0] bv);
    logic [31:0] prev;
    int lat, nbusy;
    prev = get_prod(w);
    @(negedge clk);
    set_in(w, 1'b1, av, bv);
    @(negedge clk);
    // Operands scrambled right after accept: result must use captured values.
    set_in(w, 1'b0, 16'($urandom), 16'($urandom));
    wait_done(w, tag, prev, lat, nbusy);
    check({tag, "_prod"}, get_prod(w), ref_prod(av, bv, w));
    check({tag, "_lat"}, 32'(lat), 32'(ref_lat(av, bv, w)));
    check({tag, "_busy"}, 32'(nbusy), 32'(ref_lat(av, bv, w)));
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, get_busy(w), get_done(w)}, 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    int lat, nbusy;

    rst_n = 1'b0;
    set_in(4, 1'b0, '0, '0);
    set_in(8, 1'b0, '0, '0);
    set_in(16, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_p8", get_prod(8), 32'd0);
    check("rst_flags8", {30'd0, busy8, done8}, 32'd0);
    check("rst_p16", get_prod(16), 32'd0);
    rst_n = 1'b1;

    // Directed WIDTH=8
    run_op(8, "w8_7x3", 16'd7, 16'd3);
    check("w8_7x3_const", get_prod(8), 32'h0015);
    run_op(8, "w8_80x80", 16'h80, 16'h80);
    check("w8_80x80_const", get_prod(8), 32'h4000);
    run_op(8, "w8_80x7f", 16'h80, 16'h7F);
    check("w8_80x7f_const", get_prod(8), 32'hC080);
    run_op(8, "w8_7fx7f", 16'h7F, 16'h7F);
    run_op(8, "w8_ffxff", 16'hFF, 16'hFF);
    run_op(8, "w8_0x5", 16'd0, 16'd5);
    run_op(8, "w8_5x0", 16'd5, 16'd0);
    run_op(8, "w8_m5x6", 16'hFB, 16'd6);

    // Handshake: start held high, operands changed during CALC.
    prev = get_prod(8);
    @(negedge clk);
    set_in(8, 1'b1, 16'd3, 16'd5);
    @(negedge clk);
    @(negedge clk);
    set_in(8, 1'b1, 16'd9, 16'hFE);
    wait_done(8, "hs1", prev, lat, nbusy);
    check("hs1_prod", get_prod(8), 32'd15);
    check("hs1_lat", 32'(lat - 1), 32'd9 - 32'd2);
    @(negedge clk);
    check("hs_idle_gap", {31'd0, busy8}, 32'd0);
    @(negedge clk);
    check("hs2_accepted", {31'd0, busy8}, 32'd1);
    set_in(8, 1'b0, 16'd0, 16'd0);
    prev = get_prod(8);
    wait_done(8, "hs2", prev, lat, nbusy);
    check("hs2_prod", get_prod(8), 32'hFFEE);
    check("hs2_lat", 32'(lat), 32'd9);

    // Reset mid-operation after 4 CALC iterations.
    @(negedge clk);
    set_in(8, 1'b1, 16'd7, 16'd3);
    @(negedge clk);
    set_in(8, 1'b0, 16'd0, 16'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_prod", get_prod(8), 32'd0);
    check("rst_mid_flags", {30'd0, busy8, done8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8, "w8_after_rst", 16'hFB, 16'd6);
    check("w8_after_rst_const", get_prod(8), 32'hFFE2);

    // WIDTH=4 directed
    run_op(4, "w4_8x7", 16'h8, 16'h7);
    check("w4_8x7_const", get_prod(4), 32'hC8);
    run_op(4, "w4_8x8", 16'h8, 16'h8);

    // WIDTH=16 corners
    run_op(16, "w16_min_min", 16'h8000, 16'h8000);
    run_op(16, "w16_min_max", 16'h8000, 16'h7FFF);

    // Random sweeps
    for (int i = 0; i < 40; i++) run_op(4, "rnd4", 16'($urandom), 16'($urandom));
    for (int i = 0; i < 40; i++) run_op(8, "rnd8", 16'($urandom), 16'($urandom));
    for (int i = 0; i < 30; i++) run_op(16, "rnd16", 16'($urandom), 16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
